// File: rtl/ll_pkg.sv
// Shared width helpers and parameter legality checks for the line-length window summer.
package ll_pkg;

    function automatic int ch_w(input int nch);
        return (nch > 1) ? $clog2(nch) : 1;
    endfunction

    function automatic int ptr_w(input int win);
        return $clog2(win);
    endfunction

    function automatic int diff_w(input int in_w);
        return in_w + 1;
    endfunction

    // Worst-case sum is WIN differences of up to IN_W+1 bits each.
    function automatic bit out_w_ok(input int in_w, input int win, input int out_w);
        return out_w >= (in_w + 1 + $clog2(win));
    endfunction

    function automatic bit is_pow2(input int n);
        return (n >= 1) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/ll_diff_ram.sv
// Simple dual-port ring storage for |diff| history: one write port, one registered read port.
module ll_diff_ram #(
    parameter int DEPTH  = 128,
    parameter int WIDTH  = 33,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/ll_window_sum.sv
// Per-channel sliding-window line-length (sum of |din - previous din|) over WIN differences,
// time-multiplexed across NCH channels with a fixed 2-cycle latency.
module ll_window_sum
    import ll_pkg::*;
#(
    parameter int NCH   = 4,
    parameter int IN_W  = 32,
    parameter int WIN   = 32,
    parameter int OUT_W = 64,
    localparam int CH_W = ch_w(NCH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic [CH_W-1:0]        in_ch,
    input  logic signed [IN_W-1:0] din,
    input  logic                   clr,
    input  logic [CH_W-1:0]        clr_ch,
    output logic                   out_valid,
    output logic [CH_W-1:0]        out_ch,
    output logic [OUT_W-1:0]       dout,
    output logic                   out_full
);

    localparam int DIFF_W = diff_w(IN_W);
    localparam int PTR_W  = ptr_w(WIN);
    localparam int FILL_W = PTR_W + 1;
    localparam int DEPTH  = NCH * WIN;
    localparam int ADDR_W = $clog2(DEPTH);
    localparam logic [CH_W-1:0]   CH_MASK  = CH_W'(NCH - 1);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(WIN);

    if (!out_w_ok(IN_W, WIN, OUT_W)) begin : g_bad_out_w
        $error("ll_window_sum: OUT_W too narrow for IN_W and WIN");
    end
    if (!is_pow2(NCH) || !is_pow2(WIN) || WIN < 2) begin : g_bad_geom
        $error("ll_window_sum: NCH and WIN must be powers of 2, WIN >= 2");
    end

    // Per-channel state. Pointer/fill/last/primed advance at input time, so the
    // next sample of the same channel always sees them current; the sum is the
    // only state updated one stage later and is read there too.
    logic signed [IN_W-1:0] last_reg   [NCH];
    logic                   primed_reg [NCH];
    logic [FILL_W-1:0]      fill_reg   [NCH];
    logic [PTR_W-1:0]       ptr_reg    [NCH];
    logic [OUT_W-1:0]       sum_reg    [NCH];

    logic [CH_W-1:0]   ch;
    logic [CH_W-1:0]   clr_ch_m;
    logic [DIFF_W-1:0] diff_raw;
    logic [DIFF_W-1:0] diff_next;
    logic              evict_next;
    logic [FILL_W-1:0] fill_next;
    logic [ADDR_W-1:0] addr_next;

    logic              s1_valid_reg;
    logic [CH_W-1:0]   s1_ch_reg;
    logic [DIFF_W-1:0] s1_diff_reg;
    logic              s1_evict_reg;
    logic              s1_full_reg;
    logic [ADDR_W-1:0] s1_addr_reg;
    logic              s1_clr_reg;
    logic [CH_W-1:0]   s1_clr_ch_reg;

    logic [DIFF_W-1:0] evict_data;
    logic [OUT_W-1:0]  sum_next;

    assign ch       = in_ch & CH_MASK;
    assign clr_ch_m = clr_ch & CH_MASK;

    always_comb begin
        diff_raw   = {din[IN_W-1], din} - {last_reg[ch][IN_W-1], last_reg[ch]};
        diff_next  = '0;
        if (primed_reg[ch]) begin
            diff_next = diff_raw[DIFF_W-1] ? (~diff_raw + 1'b1) : diff_raw;
        end
        evict_next = (fill_reg[ch] == FILL_MAX);
        fill_next  = evict_next ? FILL_MAX : fill_reg[ch] + 1'b1;
        addr_next  = ADDR_W'({ch, ptr_reg[ch]});
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NCH; i++) begin
                last_reg[i]   <= '0;
                primed_reg[i] <= 1'b0;
                fill_reg[i]   <= '0;
                ptr_reg[i]    <= '0;
            end
            s1_valid_reg  <= 1'b0;
            s1_ch_reg     <= '0;
            s1_diff_reg   <= '0;
            s1_evict_reg  <= 1'b0;
            s1_full_reg   <= 1'b0;
            s1_addr_reg   <= '0;
            s1_clr_reg    <= 1'b0;
            s1_clr_ch_reg <= '0;
        end else begin
            s1_valid_reg  <= in_valid;
            s1_ch_reg     <= ch;
            s1_diff_reg   <= diff_next;
            s1_evict_reg  <= evict_next;
            s1_full_reg   <= (fill_next == FILL_MAX);
            s1_addr_reg   <= addr_next;
            s1_clr_reg    <= clr;
            s1_clr_ch_reg <= clr_ch_m;
            if (in_valid) begin
                last_reg[ch]   <= din;
                primed_reg[ch] <= 1'b1;
                fill_reg[ch]   <= fill_next;
                ptr_reg[ch]    <= ptr_reg[ch] + 1'b1;
            end
            // Placed after the sample update so a same-cycle sample is the last pre-clear one.
            if (clr) begin
                primed_reg[clr_ch_m] <= 1'b0;
                fill_reg[clr_ch_m]   <= '0;
                ptr_reg[clr_ch_m]    <= '0;
            end
        end
    end

    // Evicted entry is only consumed when the window is full, so stale RAM is harmless.
    ll_diff_ram #(
        .DEPTH (DEPTH),
        .WIDTH (DIFF_W)
    ) u_diff_ram (
        .clk   (clk),
        .we    (s1_valid_reg),
        .waddr (s1_addr_reg),
        .wdata (s1_diff_reg),
        .raddr (addr_next),
        .rdata (evict_data)
    );

    assign sum_next = sum_reg[s1_ch_reg] + OUT_W'(s1_diff_reg)
                    - (s1_evict_reg ? OUT_W'(evict_data) : '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NCH; i++) begin
                sum_reg[i] <= '0;
            end
            out_valid <= 1'b0;
            out_ch    <= '0;
            dout      <= '0;
            out_full  <= 1'b0;
        end else begin
            out_valid <= s1_valid_reg;
            if (s1_valid_reg) begin
                sum_reg[s1_ch_reg] <= sum_next;
                out_ch             <= s1_ch_reg;
                dout               <= sum_next;
                out_full           <= s1_full_reg;
            end
            // Sum clear trails the other state by one stage, matching where the sum lives.
            if (s1_clr_reg) begin
                sum_reg[s1_clr_ch_reg] <= '0;
            end
        end
    end

endmodule

// File: doc/ll_window_sum.md
LL_WINDOW_SUM -- requirements
Module: ll_window_sum

Interface
REQ-001 SHALL have parameter NCH, default 4: number of time-multiplexed channels, power of 2, ≥1.
REQ-002 SHALL have parameter IN_W, default 32: signed sample width.
REQ-003 SHALL have parameter WIN, default 32: window length in differences, power of 2, ≥2.
REQ-004 SHALL have parameter OUT_W, default 64: unsigned sum width; elaboration SHALL fail if OUT_W < IN_W+1+log2(WIN).
REQ-005 SHALL have port clk, input, 1: clock, all logic on rising edge.
REQ-006 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-007 SHALL have port in_valid, input, 1: din/in_ch qualify this cycle; no backpressure, accepted every cycle.
REQ-008 SHALL have port in_ch, input, log2(NCH) (min 1): channel of din.
REQ-009 SHALL have port din, input, IN_W signed: sample.
REQ-010 SHALL have port clr, input, 1: clears channel clr_ch state.
REQ-011 SHALL have port clr_ch, input, log2(NCH): channel cleared by clr.
REQ-012 SHALL have port out_valid, output, 1: dout/out_ch/out_full valid.
REQ-013 SHALL have port out_ch, output, log2(NCH): channel of the result.
REQ-014 SHALL have port dout, output, OUT_W unsigned: line-length sum of the window.
REQ-015 SHALL have port out_full, output, 1: window of out_ch holds WIN differences.

Function
REQ-016 SHALL keep, per channel: last sample, primed flag, fill count 0..WIN, write pointer, running sum, and WIN-entry ring of |diff| (IN_W+1 bits).
REQ-017 SHALL compute diff = din − last sample at IN_W+1 bits and take its magnitude, with no wrap; the first sample after reset or clear (unprimed) SHALL yield diff 0 and set primed.
REQ-018 SHALL update sum = sum + diff − evicted, where evicted = the oldest ring entry if fill count == WIN, else 0; the new diff SHALL overwrite that entry and the pointer SHALL wrap modulo WIN.
REQ-019 SHALL saturate the fill count at WIN; out_full = (fill count after update == WIN).
REQ-020 SHALL produce out_valid exactly 2 cycles after in_valid, with out_ch = in_ch and dout = the updated sum.
REQ-021 SHALL produce results identical to serial processing for any channel sequence, including the same channel on consecutive cycles; in-flight hazards SHALL be resolved by forwarding, never by stalling.
REQ-022 SHALL hold out_valid low and hold the previous outputs when no sample is in flight.
REQ-023 SHALL zero the channel's sum, fill count, pointer, and primed flag when clr is asserted; samples for that channel still in flight SHALL complete with pre-clear state.
REQ-024 SHALL apply clr after the sample when clr and in_valid target the same channel in the same cycle, making that sample the last pre-clear sample.

Reset
REQ-025 SHALL, on rst, clear all channel state, the pipeline, out_valid, out_ch, dout, and out_full to 0 on the next edge.
REQ-026 SHALL drop in-flight samples on rst, with no out_valid for them; in_valid during rst SHALL be ignored.
REQ-027 SHALL leave ring RAM contents undefined after reset; they are never read before being written, because fill count gates eviction.

Structure
REQ-028 SHALL place width helpers (CH_W, DIFF_W, PTR_W) and the OUT_W legality check in shared package ll_pkg.
REQ-029 SHALL implement the ring storage as sub-module ll_diff_ram: NCH*WIN × DIFF_W, one read and one write port, 1-cycle read latency, inferable as block RAM.

Verification (NCH=2, WIN=4, IN_W=32, OUT_W=64)
REQ-030 SHALL cover priming: after rst, ch0 samples 10, 13, 9 -> dout 0, 3, 7; out_full 0, 0, 0; each result 2 cycles after input.
REQ-031 SHALL cover sliding: ch0 samples 0, 5, 5, 10, 4, 4 -> dout 0, 5, 5, 10, 16, 11; out_full 0, 0, 0, 1, 1, 1.
REQ-032 SHALL cover interleaving: back-to-back ch0 = 1, 4 interleaved with ch1 = 100, 90, then ch0 = 6 on consecutive cycles -> ch0 results 0, 3, 5; ch1 results 0, 10.
REQ-033 SHALL cover extremes: ch1 samples −2147483648 then 2147483647 -> dout 4294967295, with no wrap.
REQ-034 SHALL cover clr: with ch0 full at sum 16, assert clr on ch0 concurrent with a ch0 sample of 20 -> that result uses pre-clear state; the next ch0 sample -> dout 0, out_full 0; ch1 is unaffected.
REQ-035 SHALL cover reset: rst mid-stream with in_valid high for 2 cycles -> no out_valid for dropped samples, all outputs 0, and the next sample per channel primes to dout 0.
